addsub_pipe: RTL and testbench

- Parametrised, pipelined successor to the datapath's 32-bit combinational add/sub unit.
- Splits the carry chain into SEGS registered segments and moves operations through a valid/ready stream, one operation per cycle.
- Produces the same four modes and flags as the existing unit, plus a tag pass-through and a saturating overflow-event counter.
- Used by the multi-cycle ALU path and by the address-generation stage.

---
 rtl/addsub_pipe_if.sv | 36 +++
 rtl/addsub_pipe.sv | 151 +++++++++++++++
 tb/tb_addsub_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// Stream interface for addsub_pipe: operation request, result/flags response,
// and the overflow-event counter with its clear.
interface addsub_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       aluc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr;

    modport master (
        output in_valid, a, b, aluc, in_tag, out_ready, ovf_clr,
        input  in_ready, out_valid, result, zero, carry, negative, overflow,
               out_tag, ovf_count
    );

    modport slave (
        input  in_valid, a, b, aluc, in_tag, out_ready, ovf_clr,
        output in_ready, out_valid, result, zero, carry, negative, overflow,
               out_tag, ovf_count
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: the carry chain is cut into SEGS registered segments of
// WIDTH/SEGS bits, with a bubble-collapsing valid/ready stream.
// Optional feature: define ADDSUB_SATURATE_EN to saturate out-of-range results
// (otherwise signed overflow forces 0 and unsigned results wrap).
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    addsub_pipe_if.slave  io
);
    localparam int S = WIDTH / SEGS;
    localparam int L = SEGS - 1;

    // Everything that travels with an operation between segments.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;   // low result bits accumulated so far
        logic [1:0]       aluc;
        logic [TAG_W-1:0] tag;
        logic             cy;    // carry into the next segment
    } stage_t;

    stage_t [SEGS-1:0] stg_q;
    stage_t [SEGS-1:0] stg_d;
    logic   [SEGS-1:0] vld_pipe;
    logic   [SEGS-1:0] src_v;
    logic   [SEGS-1:0] adv;
    logic   [SEGS-1:0] acc;

    logic [WIDTH-1:0] res_d;
    logic             carry_d, zero_d, neg_d, ovf_d;
    logic             carry_q, zero_q, neg_q, ovf_q;
    logic [CNT_W-1:0] ovf_cnt;

    // Per-segment add: stage k adds bits [k*S +: S] of the operation it takes in.
    always_comb begin
        stage_t         src;
        logic [S-1:0]   bseg;
        logic [S:0]     seg;
        src   = '0;
        bseg  = '0;
        seg   = '0;
        stg_d = '0;
        src_v = '0;
        for (int k = 0; k < SEGS; k++) begin
            if (k == 0) begin
                src.a    = io.a;
                src.b    = io.b;
                src.sum  = '0;
                src.aluc = io.aluc;
                src.tag  = io.in_tag;
                src.cy   = io.aluc[0];      // +1 of A + ~B + 1 for subtraction
                src_v[k] = io.in_valid;
            end else begin
                src      = stg_q[(k == 0) ? 0 : k - 1];
                src_v[k] = vld_pipe[(k == 0) ? 0 : k - 1];
            end
            bseg = src.aluc[0] ? ~src.b[k*S +: S] : src.b[k*S +: S];
            seg  = {1'b0, src.a[k*S +: S]} + {1'b0, bseg} + {{S{1'b0}}, src.cy};
            stg_d[k]                = src;
            stg_d[k].sum[k*S +: S]  = seg[S-1:0];
            stg_d[k].cy             = seg[S];
        end
    end

    // Final-segment flags and out-of-range handling of the full result.
    always_comb begin
        logic [1:0]       md;
        logic             am, bm, c;
        logic [WIDTH-1:0] r;
        md      = stg_d[L].aluc;
        am      = stg_d[L].a[WIDTH-1];
        bm      = stg_d[L].b[WIDTH-1];
        c       = stg_d[L].cy;
        r       = stg_d[L].sum;
        ovf_d   = md[1] && (md[0] ? (am != bm) : (am == bm)) && (r[WIDTH-1] != am);
        carry_d = md[1] ? 1'b0 : (md[0] ? ~c : c);
        res_d   = r;
`ifdef ADDSUB_SATURATE_EN
        if (ovf_d)
            res_d = am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else if (carry_d)               // carry_d is only ever set in unsigned modes
            res_d = md[0] ? '0 : '1;
`else
        if (ovf_d)
            res_d = '0;
`endif
        zero_d = (res_d == '0);
        neg_d  = md[1] & res_d[WIDTH-1];
    end

    // Backpressure: a stage moves on if its successor is empty or moving too.
    always_comb begin
        adv    = '0;
        adv[L] = vld_pipe[L] && io.out_ready;
        for (int k = SEGS - 2; k >= 0; k--)
            adv[k] = vld_pipe[k] && (!vld_pipe[k+1] || adv[k+1]);
        acc = ~vld_pipe | adv;
    end

    // Stage registers, output register and overflow-event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            stg_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            for (int k = 0; k < SEGS; k++) begin
                if (acc[k]) begin
                    vld_pipe[k] <= src_v[k];
                    if (src_v[k])
                        stg_q[k] <= stg_d[k];
                end
            end
            if (acc[L] && src_v[L]) begin
                stg_q[L].sum <= res_d;
                carry_q      <= carry_d;
                zero_q       <= zero_d;
                neg_q        <= neg_d;
                ovf_q        <= ovf_d;
            end
            if (io.ovf_clr)
                ovf_cnt <= '0;
            else if (adv[L] && ovf_q && !(&ovf_cnt))
                ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

    assign io.in_ready  = acc[0];
    assign io.out_valid = vld_pipe[L];
    assign io.result    = stg_q[L].sum;
    assign io.out_tag   = stg_q[L].tag;
    assign io.carry     = carry_q;
    assign io.zero      = zero_q;
    assign io.negative  = neg_q;
    assign io.overflow  = ovf_q;
    assign io.ovf_count = ovf_cnt;

    // Operands, mode and carry are no longer needed once the result is out.
    logic unused_tail;
    assign unused_tail = ^{stg_q[L].a, stg_q[L].b, stg_q[L].aluc, stg_q[L].cy};
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe (WIDTH=32, SEGS=4): single ops per mode,
// a stalled stream, mid-flight reset, counter clear and saturation.
module tb_addsub_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    addsub_pipe_if #(.WIDTH(32), .TAG_W(4), .CNT_W(16)) io ();

    addsub_pipe #(.WIDTH(32), .SEGS(4), .TAG_W(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for it (bounded), check latency/result/flags/tag, pop it.
    task automatic run_op(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [1:0] md, input logic [3:0] tg,
                          input logic [31:0] er, input logic ez, input logic ec,
                          input logic en, input logic eo);
        int n;
        io.a = ia; io.b = ib; io.aluc = md; io.in_tag = tg;
        io.in_valid = 1'b1; io.out_ready = 1'b1;
        tick();
        io.in_valid = 1'b0;
        n = 1;
        while (!io.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk({nm, ".lat"}, 64'(n), 64'(4));
        chk({nm, ".res"}, 64'(io.result), 64'(er));
        chk({nm, ".zero"}, 64'(io.zero), 64'(ez));
        chk({nm, ".carry"}, 64'(io.carry), 64'(ec));
        chk({nm, ".neg"}, 64'(io.negative), 64'(en));
        chk({nm, ".ovf"}, 64'(io.overflow), 64'(eo));
        chk({nm, ".tag"}, 64'(io.out_tag), 64'(tg));
        tick();
    endtask

    initial begin
        int sent, got, last_out, stale, n;
        rst = 1'b1;
        io.in_valid = 1'b0; io.out_ready = 1'b0; io.ovf_clr = 1'b0;
        io.a = '0; io.b = '0; io.aluc = '0; io.in_tag = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst.out_valid", 64'(io.out_valid), 64'(0));
        chk("rst.in_ready", 64'(io.in_ready), 64'(1));
        chk("rst.result", 64'(io.result), 64'(0));
        chk("rst.tag", 64'(io.out_tag), 64'(0));
        chk("rst.flags", 64'({io.zero, io.carry, io.negative, io.overflow}), 64'(0));
        chk("rst.cnt", 64'(io.ovf_count), 64'(0));

        run_op("uadd_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 4'h1,
               SAT ? 32'hFFFF_FFFF : 32'h0, !SAT, 1'b1, 1'b0, 1'b0);
        run_op("sadd_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 4'h2,
               SAT ? 32'h7FFF_FFFF : 32'h0, !SAT, 1'b0, 1'b0, 1'b1);
        chk("cnt.after1", 64'(io.ovf_count), 64'(1));
        run_op("usub_brw", 32'h0000_0003, 32'h0000_0005, 2'b01, 4'h3,
               SAT ? 32'h0 : 32'hFFFF_FFFE, SAT, 1'b1, 1'b0, 1'b0);
        run_op("ssub_neg", 32'h0000_0003, 32'h0000_0005, 2'b11, 4'h4,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("ssub_ovf", 32'h8000_0000, 32'h0000_0001, 2'b11, 4'h5,
               SAT ? 32'h8000_0000 : 32'h0, !SAT, 1'b0, SAT, 1'b1);
        chk("cnt.after2", 64'(io.ovf_count), 64'(2));
        run_op("uadd_plain", 32'h1234_5678, 32'h1111_1111, 2'b00, 4'h6,
               32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sadd_negneg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 4'h7,
               32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stream of 8 unsigned adds with the consumer stalled in cycles 5..7.
        sent = 0; got = 0; last_out = -1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            io.in_valid  = (sent < 8);
            io.a         = 32'(32'h0100_0000 * sent);
            io.b         = 32'(sent + 1);
            io.aluc      = 2'b00;
            io.in_tag    = 4'(sent);
            io.out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                chk("strm.in_ready_full", 64'(io.in_ready), 64'(0));
                chk("strm.hold_valid", 64'(io.out_valid), 64'(1));
                chk("strm.hold_tag", 64'(io.out_tag), 64'(got));
            end
            if (io.out_valid && io.out_ready) begin
                chk("strm.tag", 64'(io.out_tag), 64'(got));
                chk("strm.res", 64'(io.result), 64'(32'(32'h0100_0000 * got + got + 1)));
                got++;
                last_out = cyc;
            end
            if (io.in_valid && io.in_ready) sent++;
            tick();
        end
        io.in_valid = 1'b0;
        chk("strm.sent", 64'(sent), 64'(8));
        chk("strm.got", 64'(got), 64'(8));
        chk("strm.last_cycle", 64'(last_out), 64'(14));

        // Reset with three ops in flight.
        io.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io.in_valid = 1'b1; io.a = 32'(i + 10); io.b = 32'h1; io.aluc = 2'b00; io.in_tag = 4'(i);
            tick();
        end
        io.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.out_valid", 64'(io.out_valid), 64'(0));
        chk("mrst.result", 64'(io.result), 64'(0));
        chk("mrst.cnt", 64'(io.ovf_count), 64'(0));
        chk("mrst.in_ready", 64'(io.in_ready), 64'(1));
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            if (io.out_valid) stale++;
            tick();
        end
        chk("mrst.stale", 64'(stale), 64'(0));

        // Clear takes priority over a coinciding overflow transfer.
        run_op("sadd_ovf2", 32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 4'h9,
               SAT ? 32'h7FFF_FFFF : 32'h0, !SAT, 1'b0, 1'b0, 1'b1);
        chk("clr.before", 64'(io.ovf_count), 64'(1));
        io.in_valid = 1'b1; io.out_ready = 1'b0;
        tick();
        io.in_valid = 1'b0;
        n = 1;
        while (!io.out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("clr.ovf_flag", 64'(io.overflow), 64'(1));
        io.out_ready = 1'b1; io.ovf_clr = 1'b1;
        tick();
        io.ovf_clr = 1'b0;
        chk("clr.cnt", 64'(io.ovf_count), 64'(0));

        // Saturation of the counter: 65537 overflow transfers stop at FFFF.
        io.a = 32'h7FFF_FFFF; io.b = 32'h1; io.aluc = 2'b10; io.out_ready = 1'b1;
        sent = 0;
        for (int c = 0; c < 70000 && sent < 65537; c++) begin
            io.in_valid = 1'b1;
            #1;
            if (io.in_ready) sent++;
            tick();
        end
        io.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("sat.sent", 64'(sent), 64'(65537));
        chk("sat.cnt", 64'(io.ovf_count), 64'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
